// File: rtl/dflow_sbus_pkg.sv
// Shared sideband-bus definitions: beat-position CTL codes and the counter step rule.
package dflow_sbus_pkg;

    localparam int unsigned CTL_W = 8;

    typedef logic [CTL_W-1:0] ctl_t;

    localparam ctl_t CTL_FIRST = 8'hFF;
    localparam ctl_t CTL_LAST  = 8'h01;
    localparam ctl_t CTL_FLOOR = 8'h02;

    // Position counter: reload on a last beat, otherwise count down and stick at the floor.
    function automatic ctl_t ctl_next(input ctl_t cur, input logic last);
        if (last) begin
            return CTL_FIRST;
        end
        if (cur > CTL_FLOOR) begin
            return cur - ctl_t'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/sbus_sync_fifo.sv
// Single-clock FIFO; writes become visible to the read side one cycle after they land,
// which gives the buffer its fixed two-edge accept-to-output latency.
module sbus_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_vis_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            wr_vis_q <= wr_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Occupancy and full track the true write pointer; empty tracks the delayed copy.
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (AW+1)'(DEPTH));
    assign empty_o   = (rd_ptr_q == wr_vis_q);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/a2s_stream_buf.sv
// AXI-Stream to sideband-bus beat buffer: tags each beat with a position code,
// optionally byte-reverses data/keep, buffers in a FIFO and drives a registered output stage.
module a2s_stream_buf
    import dflow_sbus_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 256,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BYTE_SWAP   = 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     S_AXIS_TVALID,
    input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                     S_AXIS_TLAST,
    output logic                     S_AXIS_TREADY,
    output logic                     M_SBUS_VALID,
    input  logic                     M_SBUS_READY,
    output logic [TDATA_WIDTH-1:0]   M_SBUS_TDATA,
    output logic [TDATA_WIDTH/8-1:0] M_SBUS_TKEEP,
    output logic [7:0]               M_SBUS_CTL,
    output logic [31:0]              PKT_CNT
);

    localparam int unsigned KW = TDATA_WIDTH / 8;
    localparam int unsigned EW = TDATA_WIDTH + KW + CTL_W;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                   tready_q, tready_d;
    ctl_t                   ctr_q, ctr_d;
    logic                   valid_q, valid_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [KW-1:0]          keep_q, keep_d;
    ctl_t                   ctl_q, ctl_d;
    logic [31:0]            pkt_q, pkt_d;

    logic                   push, pop, load;
    logic [TDATA_WIDTH-1:0] sw_data;
    logic [KW-1:0]          sw_keep;
    ctl_t                   tag_ctl;
    logic [EW-1:0]          fifo_wdata, fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count, occ_d;

    always_comb begin
        sw_data = S_AXIS_TDATA;
        sw_keep = S_AXIS_TKEEP;
        if (BYTE_SWAP != 0) begin
            for (int unsigned i = 0; i < KW; i++) begin
                sw_data[8*(KW-1-i) +: 8] = S_AXIS_TDATA[8*i +: 8];
                sw_keep[KW-1-i]          = S_AXIS_TKEEP[i];
            end
        end
    end

    assign push       = S_AXIS_TVALID && tready_q && !fifo_full;
    assign tag_ctl    = S_AXIS_TLAST ? CTL_LAST : ctr_q;
    assign fifo_wdata = {sw_data, sw_keep, tag_ctl};

    // The output stage refills whenever it is empty or its beat is being taken this cycle.
    assign load = !valid_q || M_SBUS_READY;
    assign pop  = load && !fifo_empty;

    sbus_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .wr_en_i   (push),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        ctr_d    = push ? ctl_next(ctr_q, S_AXIS_TLAST) : ctr_q;
        occ_d    = fifo_count + CW'(push) - CW'(pop);
        tready_d = (occ_d < CW'(FIFO_DEPTH));
        valid_d  = valid_q;
        data_d   = data_q;
        keep_d   = keep_q;
        ctl_d    = ctl_q;
        if (load) begin
            valid_d = !fifo_empty;
            if (fifo_empty) begin
                {data_d, keep_d, ctl_d} = '0;
            end else begin
                {data_d, keep_d, ctl_d} = fifo_rdata;
            end
        end
        pkt_d = pkt_q + 32'(valid_q && M_SBUS_READY && (ctl_q == CTL_LAST));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tready_q <= 1'b0;
            ctr_q    <= CTL_FIRST;
            valid_q  <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            ctl_q    <= '0;
            pkt_q    <= '0;
        end else begin
            tready_q <= tready_d;
            ctr_q    <= ctr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            ctl_q    <= ctl_d;
            pkt_q    <= pkt_d;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign M_SBUS_VALID  = valid_q;
    assign M_SBUS_TDATA  = data_q;
    assign M_SBUS_TKEEP  = keep_q;
    assign M_SBUS_CTL    = ctl_q;
    assign PKT_CNT       = pkt_q;

endmodule

// File: tb/tb_a2s_stream_buf.sv
// Scoreboard bench for a2s_stream_buf: byte-swapped main instance plus a pass-through twin.
module tb_a2s_stream_buf;

    localparam int unsigned DW    = 256;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [7:0]    ctl;
    } beat_t;

    logic          ACLK   = 1'b0;
    logic          ARESET = 1'b0;
    logic          s_tvalid, s_tlast, m_ready;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;

    logic          s_tready, m_valid;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [7:0]    m_ctl;
    logic [31:0]   pkt_cnt;

    logic          ns_tready, ns_valid;
    logic [DW-1:0] ns_tdata;
    logic [KW-1:0] ns_tkeep;
    logic [7:0]    ns_ctl;
    logic [31:0]   ns_pkt_cnt;

    beat_t         exp_q[$];
    logic [7:0]    obs_ctl[$];
    logic [DW-1:0] obs_data[$];
    logic [DW-1:0] obs_data_ns[$];

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    int unsigned   n_acc = 0;
    int unsigned   exp_pkts = 0;
    logic [7:0]    m_ctr = 8'hFF;

    logic          prev_v = 1'b0, prev_r = 1'b0;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;
    logic [7:0]    prev_c;

    always #5 ACLK = ~ACLK;

    a2s_stream_buf #(.TDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BYTE_SWAP(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
        .M_SBUS_VALID(m_valid), .M_SBUS_READY(m_ready), .M_SBUS_TDATA(m_tdata),
        .M_SBUS_TKEEP(m_tkeep), .M_SBUS_CTL(m_ctl), .PKT_CNT(pkt_cnt)
    );

    a2s_stream_buf #(.TDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BYTE_SWAP(0)) dut_ns (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(ns_tready),
        .M_SBUS_VALID(ns_valid), .M_SBUS_READY(m_ready), .M_SBUS_TDATA(ns_tdata),
        .M_SBUS_TKEEP(ns_tkeep), .M_SBUS_CTL(ns_ctl), .PKT_CNT(ns_pkt_cnt)
    );

    function automatic logic [DW-1:0] swap_data(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(KW); i++) r[DW-8-8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [KW-1:0] swap_keep(input logic [KW-1:0] k);
        logic [KW-1:0] r;
        for (int i = 0; i < int'(KW); i++) r[KW-1-i] = k[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW/32); i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake (sampled mid-cycle).
    always @(negedge ACLK) begin
        beat_t b;
        if (!ARESET) begin
            if (s_tvalid && s_tready) begin
                b.data = swap_data(s_tdata);
                b.keep = swap_keep(s_tkeep);
                b.ctl  = s_tlast ? 8'h01 : m_ctr;
                exp_q.push_back(b);
                n_acc++;
                if (s_tlast) m_ctr = 8'hFF;
                else if (m_ctr > 8'h02) m_ctr = m_ctr - 8'h01;
            end
            if (prev_v && !prev_r) begin
                n_cmp++;
                if ({m_valid, m_tdata, m_tkeep, m_ctl} !== {1'b1, prev_d, prev_k, prev_c}) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%0b ctl=%02h data=%h, required valid=1 ctl=%02h data=%h",
                             m_valid, m_ctl, m_tdata, prev_c, prev_d);
                end
            end
            if (!m_valid) begin
                n_cmp++;
                if ({m_tdata, m_tkeep, m_ctl} !== '0) begin
                    n_err++;
                    $display("FAIL idle_zero: got ctl=%02h keep=%h data=%h, required all zero",
                             m_ctl, m_tkeep, m_tdata);
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra_beat: got ctl=%02h data=%h, required no beat", m_ctl, m_tdata);
                end else begin
                    b = exp_q.pop_front();
                    if ({m_tdata, m_tkeep, m_ctl} !== {b.data, b.keep, b.ctl}) begin
                        n_err++;
                        $display("FAIL sb_beat: got ctl=%02h keep=%h data=%h, required ctl=%02h keep=%h data=%h",
                                 m_ctl, m_tkeep, m_tdata, b.ctl, b.keep, b.data);
                    end
                end
                obs_ctl.push_back(m_ctl);
                obs_data.push_back(m_tdata);
                obs_data_ns.push_back(ns_tdata);
                if (m_ctl == 8'h01) exp_pkts++;
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_tdata;
            prev_k = m_tkeep;
            prev_c = m_ctl;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, output bit ok);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge ACLK);
            if (s_tready) ok = 1'b1;
            @(posedge ACLK);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge ACLK);
            #1;
            if (exp_q.size() == 0 && !m_valid) ok = 1'b1;
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_obs();
        obs_ctl.delete();
        obs_data.delete();
        obs_data_ns.delete();
    endtask

    task automatic test_reset();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; m_ready = 1'b0;
        #1 ARESET = 1'b1;
        exp_q.delete(); clear_obs(); m_ctr = 8'hFF; exp_pkts = 0;
        repeat (3) @(posedge ACLK);
        #2;
        n_cmp++;
        if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b, required 0", s_tready); end
        n_cmp++;
        if ({m_valid, m_tdata, m_tkeep, m_ctl} !== '0) begin
            n_err++; $display("FAIL rst_outputs: got valid=%b ctl=%02h data=%h, required 0", m_valid, m_ctl, m_tdata);
        end
        n_cmp++;
        if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rst_pktcnt: got %0d, required 0", pkt_cnt); end
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        n_cmp++;
        if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_release_tready: got %b, required 1", s_tready); end
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        m_ready = 1'b1;
        clear_obs();
        d = rand_data();
        s_tdata = d; s_tkeep = '1; s_tlast = 1'b1; s_tvalid = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if (s_tready !== 1'b1) begin n_err++; $display("FAIL single_accept: got tready=%b, required 1", s_tready); end
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_lat_k0: got valid=%b, required 0", m_valid); end
        @(negedge ACLK);
        n_cmp++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_lat_k1: got valid=%b, required 0", m_valid); end
        @(negedge ACLK);
        n_cmp++;
        if ({m_valid, m_ctl} !== {1'b1, 8'h01}) begin
            n_err++; $display("FAIL single_lat_k2: got valid=%b ctl=%02h, required valid=1 ctl=01", m_valid, m_ctl);
        end
        repeat (3) @(posedge ACLK);
        #1;
        n_cmp++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL single_pktcnt: got %0d, required 1", pkt_cnt); end
    endtask

    task automatic test_swap();
        logic [7:0] want[4];
        logic [DW-1:0] d;
        bit ok;
        want[0] = 8'hFF; want[1] = 8'hFE; want[2] = 8'hFD; want[3] = 8'h01;
        m_ready = 1'b1;
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            d = rand_data();
            d[7:0] = 8'hAA;
            send_beat(d, KW'($urandom), (i == 3), ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL swap_send_timeout: beat %0d not accepted", i); end
        end
        wait_drain(ok);
        n_cmp++;
        if (!ok || obs_ctl.size() != 4) begin
            n_err++; $display("FAIL swap_count: got %0d beats, required 4", obs_ctl.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_ctl[i] !== want[i]) begin
                    n_err++; $display("FAIL swap_ctl[%0d]: got %02h, required %02h", i, obs_ctl[i], want[i]);
                end
                n_cmp++;
                if (obs_data[i][DW-1 -: 8] !== 8'hAA) begin
                    n_err++; $display("FAIL swap_top_byte[%0d]: got %02h, required aa", i, obs_data[i][DW-1 -: 8]);
                end
                n_cmp++;
                if (obs_data_ns[i][7:0] !== 8'hAA) begin
                    n_err++; $display("FAIL noswap_byte0[%0d]: got %02h, required aa", i, obs_data_ns[i][7:0]);
                end
            end
        end
    endtask

    task automatic test_long_packet();
        bit ok;
        int unsigned n_floor;
        m_ready = 1'b1;
        clear_obs();
        for (int i = 0; i < 302; i++) begin
            send_beat(rand_data(), '1, (i == 299 || i == 301), ok);
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL long_send_timeout: beat %0d not accepted", i);
                break;
            end
        end
        wait_drain(ok);
        n_cmp++;
        if (!ok || obs_ctl.size() != 302) begin
            n_err++; $display("FAIL long_count: got %0d beats, required 302", obs_ctl.size());
        end else begin
            n_floor = 0;
            for (int i = 0; i < 302; i++) if (obs_ctl[i] == 8'h02) n_floor++;
            n_cmp++;
            if (n_floor != 46) begin n_err++; $display("FAIL long_floor_count: got %0d, required 46", n_floor); end
            n_cmp++;
            if ({obs_ctl[0], obs_ctl[252], obs_ctl[253]} !== {8'hFF, 8'h03, 8'h02}) begin
                n_err++; $display("FAIL long_descent: got %02h %02h %02h, required ff 03 02",
                                  obs_ctl[0], obs_ctl[252], obs_ctl[253]);
            end
            n_cmp++;
            if ({obs_ctl[298], obs_ctl[299], obs_ctl[300], obs_ctl[301]} !== {8'h02, 8'h01, 8'hFF, 8'h01}) begin
                n_err++; $display("FAIL long_tail: got %02h %02h %02h %02h, required 02 01 ff 01",
                                  obs_ctl[298], obs_ctl[299], obs_ctl[300], obs_ctl[301]);
            end
        end
    endtask

    task automatic test_backpressure();
        int unsigned acc0;
        logic acc;
        logic [DW-1:0] held;
        bit ok;
        m_ready = 1'b0;
        clear_obs();
        acc0 = n_acc;
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = rand_data(); s_tkeep = KW'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(negedge ACLK);
            acc = s_tready;
            @(posedge ACLK);
            #1;
            if (acc) begin s_tdata = rand_data(); s_tkeep = KW'($urandom); end
        end
        s_tvalid = 1'b0;
        n_cmp++;
        if (n_acc - acc0 != DEPTH + 1) begin
            n_err++; $display("FAIL bp_accepted: got %0d, required %0d", n_acc - acc0, DEPTH + 1);
        end
        @(negedge ACLK);
        held = m_tdata;
        n_cmp++;
        if ({s_tready, m_valid} !== 2'b01) begin
            n_err++; $display("FAIL bp_full_state: got tready=%b valid=%b, required tready=0 valid=1", s_tready, m_valid);
        end
        repeat (5) @(negedge ACLK);
        n_cmp++;
        if (m_tdata !== held) begin n_err++; $display("FAIL bp_held: got %h, required %h", m_tdata, held); end
        @(posedge ACLK);
        #1;
        m_ready = 1'b1;
        wait_drain(ok);
        n_cmp++;
        if (!ok || obs_ctl.size() != DEPTH + 1) begin
            n_err++; $display("FAIL bp_drain: got %0d beats, required %0d", obs_ctl.size(), DEPTH + 1);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_beat(rand_data(), '1, 1'b0, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL ar_send_timeout: beat %0d not accepted", i); end
        end
        #3 ARESET = 1'b1;
        #1;
        n_cmp++;
        if ({m_valid, m_tdata, m_tkeep, m_ctl, s_tready, pkt_cnt} !== '0) begin
            n_err++; $display("FAIL ar_clear: got valid=%b ctl=%02h tready=%b pkt=%0d, required all 0",
                              m_valid, m_ctl, s_tready, pkt_cnt);
        end
        exp_q.delete(); clear_obs(); m_ctr = 8'hFF; exp_pkts = 0;
        #7 ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        m_ready = 1'b1;
        send_beat(rand_data(), '1, 1'b0, ok);
        send_beat(rand_data(), '1, 1'b1, ok);
        wait_drain(ok);
        n_cmp++;
        if (!ok || obs_ctl.size() != 2) begin
            n_err++; $display("FAIL ar_count: got %0d beats, required 2", obs_ctl.size());
        end else begin
            n_cmp++;
            if ({obs_ctl[0], obs_ctl[1]} !== {8'hFF, 8'h01}) begin
                n_err++; $display("FAIL ar_first_ctl: got %02h %02h, required ff 01", obs_ctl[0], obs_ctl[1]);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL ar_pktcnt: got %0d, required 1", pkt_cnt); end
    endtask

    task automatic test_random();
        int unsigned sent, acc0;
        logic acc;
        bit ok;
        clear_obs();
        acc0 = n_acc;
        sent = 0;
        acc = 1'b0;
        s_tvalid = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            if (!s_tvalid || acc) begin
                s_tdata  = rand_data();
                s_tkeep  = KW'($urandom);
                s_tlast  = ($urandom_range(15) == 0);
                s_tvalid = ($urandom_range(3) != 0);
            end
            m_ready = ($urandom_range(3) != 0);
            @(negedge ACLK);
            acc = s_tvalid && s_tready;
            if (acc) sent++;
            @(posedge ACLK);
            #1;
        end
        s_tvalid = 1'b0;
        n_cmp++;
        if (sent < 10000) begin n_err++; $display("FAIL rand_timeout: got %0d beats sent, required 10000", sent); end
        m_ready = 1'b1;
        wait_drain(ok);
        n_cmp++;
        if (!ok || obs_ctl.size() != n_acc - acc0) begin
            n_err++; $display("FAIL rand_drain: got %0d beats out, required %0d", obs_ctl.size(), n_acc - acc0);
        end
        n_cmp++;
        if (pkt_cnt !== 32'(exp_pkts)) begin
            n_err++; $display("FAIL rand_pktcnt: got %0d, required %0d", pkt_cnt, exp_pkts);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_swap();
        test_long_packet();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/a2s_stream_buf.md
A2S_STREAM_BUF -- requirements
Module: a2s_stream_buf

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256: data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: beat buffer depth; SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter BYTE_SWAP, default 1: 1 reverses byte order of data and keep; 0 passes them straight through.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port ACLK, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port ARESET, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port S_AXIS_TVALID, input, 1 bit: input beat valid.
REQ-008 SHALL have port S_AXIS_TDATA, input, TDATA_WIDTH bits: input data.
REQ-009 SHALL have port S_AXIS_TKEEP, input, TDATA_WIDTH/8 bits: input byte enables.
REQ-010 SHALL have port S_AXIS_TLAST, input, 1 bit: last beat of packet.
REQ-011 SHALL have port S_AXIS_TREADY, output, 1 bit: buffer can accept a beat.
REQ-012 SHALL have port M_SBUS_VALID, output, 1 bit: output beat valid.
REQ-013 SHALL have port M_SBUS_READY, input, 1 bit: downstream accepts the beat.
REQ-014 SHALL have port M_SBUS_TDATA, output, TDATA_WIDTH bits: output data.
REQ-015 SHALL have port M_SBUS_TKEEP, output, TDATA_WIDTH/8 bits: output byte enables.
REQ-016 SHALL have port M_SBUS_CTL, output, 8 bits: beat position code.
REQ-017 SHALL have port PKT_CNT, output, 32 bits: count of last beats delivered downstream.

Function
REQ-018 SHALL accept an input beat on a rising edge where S_AXIS_TVALID and S_AXIS_TREADY are both 1.
REQ-019 SHALL drive S_AXIS_TREADY from registered state only: 1 iff FIFO occupancy < FIFO_DEPTH; no combinational path from M_SBUS_READY.
REQ-020 SHALL tag each accepted beat with an 8-bit CTL at accept time: a last beat gets 0x01; a non-last beat gets the current counter value.
REQ-021 SHALL initialise the counter to 0xFF, decrement it on each non-last accept, hold it at 0x02 (no decrement below 0x02), and reload it to 0xFF on a last accept.
REQ-022 SHALL map byte i of the input to byte (TDATA_WIDTH/8-1-i) of the output and keep bit i to keep bit (TDATA_WIDTH/8-1-i) when BYTE_SWAP=1; SHALL map them unchanged when BYTE_SWAP=0.
REQ-023 SHALL store {data, keep, ctl} per beat in a FIFO of FIFO_DEPTH entries, in order, with no loss or duplication.
REQ-024 SHALL implement the output stage as a register: load from the FIFO head when the stage is empty or M_SBUS_READY=1.
REQ-025 SHALL present a beat accepted at edge k into an empty block at M_SBUS outputs after edge k+2.
REQ-026 SHALL hold M_SBUS_TDATA, M_SBUS_TKEEP and M_SBUS_CTL stable while M_SBUS_VALID=1 and M_SBUS_READY=0.
REQ-027 SHALL drive M_SBUS_TDATA, M_SBUS_TKEEP and M_SBUS_CTL to 0 whenever M_SBUS_VALID=0.
REQ-028 SHALL sustain one beat per cycle when M_SBUS_READY is held at 1.
REQ-029 SHALL process a push and a pop in the same cycle with occupancy unchanged; when full, S_AXIS_TREADY rises only on the edge after the pop.
REQ-030 SHALL increment PKT_CNT when M_SBUS_VALID=1, M_SBUS_READY=1 and M_SBUS_CTL=0x01, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-031 SHALL, while ARESET=1 and independent of ACLK, clear: FIFO occupancy and pointers to 0, counter to 0xFF, S_AXIS_TREADY to 0, M_SBUS_VALID, M_SBUS_TDATA, M_SBUS_TKEEP and M_SBUS_CTL to 0, and PKT_CNT to 0.
REQ-032 SHALL raise S_AXIS_TREADY on the first edge after ARESET deasserts.
REQ-033 SHALL discard buffered beats on reset mid-packet; the next packet's first beat SHALL carry CTL 0xFF.

Structure
REQ-034 SHALL take CTL_FIRST=0xFF, CTL_LAST=0x01, CTL_FLOOR=0x02 and the CTL width from shared package dflow_sbus_pkg.
REQ-035 SHALL implement the FIFO as a separate sub-module sbus_sync_fifo (parameters WIDTH and DEPTH; outputs full, empty and count).

Verification
REQ-036 SHALL cover: single-beat packet with M_SBUS_READY=1 -> one output beat with CTL 0x01, PKT_CNT=1, and the output appears 2 cycles after accept.
REQ-037 SHALL cover: 4-beat packet, TDATA byte0=0xAA, BYTE_SWAP=1 -> CTL FF,FE,FD,01 and 0xAA in the top byte of M_SBUS_TDATA; with BYTE_SWAP=0, 0xAA stays in byte0.
REQ-038 SHALL cover: 300-beat packet -> CTL FF down to 02, 02 held for beats 254..299, last beat 01, and the next packet starts at FF.
REQ-039 SHALL cover: M_SBUS_READY=0 with continuous input -> exactly FIFO_DEPTH+1 beats accepted, then S_AXIS_TREADY=0 and the output held stable; releasing M_SBUS_READY drains all beats in order.
REQ-040 SHALL cover: ARESET pulse mid-packet asynchronous to ACLK -> outputs clear immediately, and the next packet after release begins with CTL 0xFF.
REQ-041 SHALL cover: random TVALID and M_SBUS_READY over 10k beats -> the scoreboard matches data, keep and CTL in order, and PKT_CNT equals the number of packets delivered.
